// File: rtl/enc_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : enc_seq_ctrl_if                                              |
// | Description : Decode/accelerator handshake bundle for enc_seq_ctrl.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface enc_seq_ctrl_if;
    logic       dec_valid_i;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       flush_i;
    logic       acc_ready_i;
    logic       acc_round_done_i;
    logic       acc_start_o;
    logic       acc_round_en_o;
    logic [2:0] acc_mode_o;
    logic [3:0] round_cnt_o;
    logic       stall_o;
    logic       out_of_loop_o;
    logic       err_o;

    // master: pipeline/accelerator environment; slave: the sequencer itself
    modport master (
        output dec_valid_i, op_i, funct3_i, flush_i, acc_ready_i, acc_round_done_i,
        input  acc_start_o, acc_round_en_o, acc_mode_o, round_cnt_o, stall_o,
               out_of_loop_o, err_o
    );
    modport slave (
        input  dec_valid_i, op_i, funct3_i, flush_i, acc_ready_i, acc_round_done_i,
        output acc_start_o, acc_round_en_o, acc_mode_o, round_cnt_o, stall_o,
               out_of_loop_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/enc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : enc_seq_ctrl                                                 |
// | Description : Stalls the pipeline and sequences accelerator rounds for ENC.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module enc_seq_ctrl #(
    parameter int unsigned ROUNDS  = 10,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    enc_seq_ctrl_if.slave bus
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_run   = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [6:0] c_op_enc       = 7'b0001011;
    localparam logic [2:0] c_mode_illegal = 3'b111;
    localparam logic [3:0] c_last_round   = 4'(ROUNDS - 1);
    localparam logic [7:0] c_timer_last   = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] timer_q, timer_d;
    logic       err_q, err_d;

    logic w_enc;
    logic w_accept;
    logic w_start;
    logic w_round_en;
    logic w_stall;
    logic w_ool;

    assign w_enc    = bus.dec_valid_i && (bus.op_i == c_op_enc);
    assign w_accept = w_enc && !bus.flush_i;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        err_d      = err_q;
        w_start    = 1'b0;
        w_round_en = 1'b0;
        w_stall    = 1'b0;
        w_ool      = 1'b0;
        case (state_q)
            c_idle: begin
                if (w_accept) begin
                    w_stall = 1'b1;
                    mode_d  = bus.funct3_i;
                    cnt_d   = 4'd0;
                    if (bus.funct3_i == c_mode_illegal) begin
                        err_d   = 1'b1;
                        state_d = c_done;
                    end else begin
                        err_d   = 1'b0;
                        state_d = c_start;
                    end
                end
            end
            c_start: begin
                w_stall = 1'b1;
                // A flush kills the instruction before the accelerator sees it
                if (bus.flush_i) begin
                    state_d = c_idle;
                end else if (bus.acc_ready_i) begin
                    w_start = 1'b1;
                    timer_d = 8'd0;
                    state_d = c_run;
                end
            end
            c_run: begin
                w_stall    = 1'b1;
                w_round_en = 1'b1;
                // Round completion outranks a coincident timeout
                if (bus.acc_round_done_i) begin
                    cnt_d   = cnt_q + 4'd1;
                    timer_d = 8'd0;
                    if (cnt_q == c_last_round) begin
                        state_d = c_done;
                    end
                end else if (timer_q == c_timer_last) begin
                    err_d   = 1'b1;
                    state_d = c_done;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                w_ool   = 1'b1;
                state_d = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_idle;
            mode_q  <= 3'd0;
            cnt_q   <= 4'd0;
            timer_q <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign bus.acc_start_o    = w_start;
    assign bus.acc_round_en_o = w_round_en;
    assign bus.acc_mode_o     = mode_q;
    assign bus.round_cnt_o    = cnt_q;
    assign bus.stall_o        = w_stall;
    assign bus.out_of_loop_o  = w_ool;
    assign bus.err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_enc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_enc_seq_ctrl                                              |
// | Description : Self-checking bench: vector table, directed ops, random ops. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_enc_seq_ctrl;

    localparam int ROUNDS  = 10;
    localparam int TIMEOUT = 4;
    localparam logic [6:0] c_enc = 7'b0001011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   gaps_q[$];

    enc_seq_ctrl_if bus ();

    enc_seq_ctrl #(.ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       dv;
        logic [6:0] op;
        logic [2:0] f3;
        logic       flush;
        logic       ready;
        logic       done;
        logic [11:0] exp;  // {start, round_en, stall, ool, err, cnt[3:0], mode[2:0]}
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mkv(string n, bit r, bit dv, bit [6:0] op, bit [2:0] f3,
                                 bit fl, bit rdy, bit dn, bit st, bit ren, bit stl,
                                 bit ool, bit er, bit [3:0] cnt, bit [2:0] md);
        vec_t v;
        v.name = n; v.rst = r; v.dv = dv; v.op = op; v.f3 = f3;
        v.flush = fl; v.ready = rdy; v.done = dn;
        v.exp = {st, ren, stl, ool, er, cnt, md};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic dv, input logic [6:0] op, input logic [2:0] f3,
                         input logic fl, input logic rdy, input logic dn);
        bus.dec_valid_i      = dv;
        bus.op_i             = op;
        bus.funct3_i         = f3;
        bus.flush_i          = fl;
        bus.acc_ready_i      = rdy;
        bus.acc_round_done_i = dn;
    endtask

    function automatic logic [11:0] all_outs();
        return {bus.acc_start_o, bus.acc_round_en_o, bus.stall_o, bus.out_of_loop_o,
                bus.err_o, bus.round_cnt_o, bus.acc_mode_o};
    endfunction

    // Timeline model: an operation is a ready delay plus, per round, the number of
    // silent RUN cycles before its done pulse; a gap of TIMEOUT or more expires it.
    task automatic run_op(input logic [2:0] mode, input int d, input bit noise,
                          output int obs_ool, output int obs_cnt, output int obs_err);
        int s_cyc, d_cyc, r, cnt, err;
        bit legal;
        bit done_at[0:127];
        legal = (mode != 3'b111);
        foreach (done_at[i]) done_at[i] = 1'b0;
        if (!legal) begin
            s_cyc = 0; d_cyc = 1; cnt = 0; err = 1;
        end else begin
            s_cyc = 1 + d; r = s_cyc + 1; cnt = 0; err = 0; d_cyc = -1;
            for (int k = 0; k < ROUNDS; k++) begin
                if (d_cyc < 0) begin
                    if (gaps_q[k] >= TIMEOUT) begin
                        d_cyc = r + TIMEOUT; err = 1;
                    end else begin
                        done_at[r + gaps_q[k]] = 1'b1;
                        r = r + gaps_q[k] + 1;
                        cnt++;
                    end
                end
            end
            if (d_cyc < 0) d_cyc = r;
        end
        obs_ool = -1; obs_cnt = -1; obs_err = -1;
        for (int t = 0; t <= d_cyc + 1; t++) begin
            bit in_start, in_run, quiet;
            logic [6:0] op;
            in_start = legal && (t >= 1) && (t <= s_cyc);
            in_run   = legal && (t > s_cyc) && (t < d_cyc);
            quiet    = (t == 0) || in_start || (t == d_cyc + 1);
            op       = $urandom_range(0, 1) ? c_enc : 7'($urandom_range(0, 127));
            @(posedge clk); #1;
            if (t == 0)
                drive(1'b1, c_enc, mode, 1'b0, noise & 1'($urandom), 1'b0);
            else if (t == d_cyc + 1)
                drive(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
            else
                drive(noise & 1'($urandom), op, 3'($urandom_range(0, 7)),
                      !quiet && noise && ($urandom_range(0, 3) == 0),
                      in_start ? (t == s_cyc) : (noise & 1'($urandom)),
                      in_run ? done_at[t] : (noise & 1'($urandom)));
            @(negedge clk);
            if (bus.out_of_loop_o === 1'b1 && obs_ool < 0) obs_ool = t;
            if (t <= d_cyc)
                check("op_ctrl", {bus.acc_start_o, bus.acc_round_en_o, bus.stall_o, bus.out_of_loop_o},
                      {legal && (t == s_cyc), in_run, t < d_cyc, t == d_cyc});
            else
                check("op_after", {bus.acc_start_o, bus.acc_round_en_o, bus.stall_o, bus.out_of_loop_o}, 0);
            if (t >= d_cyc)
                check("op_result", {bus.err_o, bus.round_cnt_o, bus.acc_mode_o},
                      {err[0], cnt[3:0], mode});
            if (t == d_cyc) begin
                obs_cnt = int'(bus.round_cnt_o);
                obs_err = int'(bus.err_o);
            end
        end
    endtask

    task automatic set_gaps(input int g_all, input int tmo_round);
        gaps_q.delete();
        for (int k = 0; k < ROUNDS; k++) gaps_q.push_back((k == tmo_round) ? TIMEOUT : g_all);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int o, c, e;
        drive(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset_outputs", all_outs(), 12'd0);
        drive(1'b1, c_enc, 3'd2, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_stall_enc", {bus.stall_o, bus.acc_start_o, bus.out_of_loop_o}, 3'b100);
        drive(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        vecs[0]  = mkv("idle",        0,0,7'h00,0,0,0,0, 0,0,0,0,0,0,0);
        vecs[1]  = mkv("ill_enc",     0,1,c_enc,7,0,0,0, 0,0,1,0,0,0,0);
        vecs[2]  = mkv("ill_done",    0,1,c_enc,2,0,1,1, 0,0,0,1,1,0,7);
        vecs[3]  = mkv("ill_hold",    0,0,7'h00,0,0,0,0, 0,0,0,0,1,0,7);
        vecs[4]  = mkv("enc_flushed", 0,1,c_enc,2,1,0,0, 0,0,0,0,1,0,7);
        vecs[5]  = mkv("not_enc",     0,1,7'h0C,2,0,0,0, 0,0,0,0,1,0,7);
        vecs[6]  = mkv("enc_f3",      0,1,c_enc,3,0,0,0, 0,0,1,0,1,0,7);
        vecs[7]  = mkv("start_flush", 0,0,7'h00,0,1,1,1, 0,0,1,0,0,0,3);
        vecs[8]  = mkv("flush_idle",  0,0,7'h00,0,0,1,0, 0,0,0,0,0,0,3);
        vecs[9]  = mkv("enc_f1",      0,1,c_enc,1,0,1,0, 0,0,1,0,0,0,3);
        vecs[10] = mkv("start_nrdy",  0,0,7'h00,0,0,0,0, 0,0,1,0,0,0,1);
        vecs[11] = mkv("start_rdy",   0,0,7'h00,0,0,1,0, 1,0,1,0,0,0,1);
        vecs[12] = mkv("run_done",    0,0,7'h00,0,1,0,1, 0,1,1,0,0,0,1);
        vecs[13] = mkv("run_quiet",   0,0,7'h00,0,0,0,0, 0,1,1,0,0,1,1);
        vecs[14] = mkv("async_rst",   1,0,7'h00,0,0,0,0, 0,0,0,0,0,0,0);
        vecs[15] = mkv("post_rst",    0,0,7'h00,0,0,0,0, 0,0,0,0,0,0,0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst = vecs[i].rst;
            drive(vecs[i].dv, vecs[i].op, vecs[i].f3, vecs[i].flush, vecs[i].ready, vecs[i].done);
            @(negedge clk);
            check(vecs[i].name, all_outs(), vecs[i].exp);
        end

        // Nominal: out_of_loop on the 13th cycle counting the ENC cycle
        set_gaps(0, -1);
        run_op(3'd0, 0, 1'b0, o, c, e);
        check("nominal_latency", o, 12);
        check("nominal_cnt", c, ROUNDS);
        check("nominal_err", e, 0);

        // Five cycles of backpressure stretch the latency to 18 cycles
        run_op(3'd4, 5, 1'b0, o, c, e);
        check("backpressure_latency", o, 17);
        check("backpressure_cnt", c, ROUNDS);

        // Last done at cycle 4; four silent RUN cycles expire the timer
        set_gaps(0, 3);
        run_op(3'd6, 0, 1'b0, o, c, e);
        check("timeout_ool", o, 9);
        check("timeout_cnt", c, 3);
        check("timeout_err", e, 1);

        run_op(3'b111, 0, 1'b0, o, c, e);
        check("illegal_ool", o, 1);
        check("illegal_err", e, 1);
        set_gaps(0, -1);
        run_op(3'd2, 0, 1'b0, o, c, e);
        check("legal_clears_err", e, 0);

        // Reset mid-cycle during round 5
        @(posedge clk); #1;
        drive(1'b1, c_enc, 3'd5, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 7'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("pre_rst_run", {bus.acc_round_en_o, bus.round_cnt_o, bus.acc_mode_o}, {1'b1, 4'd5, 3'd5});
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", all_outs(), 12'd0);
        drive(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_ool", {bus.out_of_loop_o, bus.stall_o, bus.acc_round_en_o}, 3'b000);
        end

        for (int n = 0; n < 40; n++) begin
            gaps_q.delete();
            for (int k = 0; k < ROUNDS; k++)
                gaps_q.push_back(($urandom_range(0, 24) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 2)
                                                              : $urandom_range(0, TIMEOUT - 1));
            run_op(3'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b1, o, c, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
